// File: rtl/end_screen_seq_pkg.sv
// rtl/end_screen_seq_pkg.sv - shared state encoding and counter width helper for the end screen
package end_screen_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REVEAL,
        S_HOLD,
        S_ARMED,
        S_DONE
    } state_t;

    // One spare bit so a counter can hold its terminal value without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/end_screen_seq_tick_divider.sv
// rtl/end_screen_seq_tick_divider.sv - counts N enabled ticks and strobes done on the Nth
module end_screen_seq_tick_divider
    import end_screen_seq_pkg::*;
#(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam int W = cnt_w(N);
    localparam logic [W-1:0] TERM = W'(N - 1);

    logic [W-1:0] r_cnt;

    assign o_done = i_en && (r_cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/end_screen_seq.sv
// rtl/end_screen_seq.sv - end-of-game overlay: score latch, best score, timed reveal, blink, restart arming
module end_screen_seq
    import end_screen_seq_pkg::*;
#(
    parameter int                    NUM_LINES    = 3,
    parameter int                    SCORE_W      = 12,
    parameter int                    REVEAL_TICKS = 1,
    parameter int                    BLINK_TICKS  = 1,
    parameter int                    ARM_TICKS    = 2,
    parameter logic [NUM_LINES-1:0]  BLINK_MASK   = 3'b100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 module_en,
    input  logic                 tick,
    input  logic [SCORE_W-1:0]   score_in,
    input  logic                 key_restart,
    output logic [NUM_LINES-1:0] line_en,
    output logic [SCORE_W-1:0]   score_out,
    output logic [SCORE_W-1:0]   best_out,
    output logic                 new_best,
    output logic                 restart_req,
    output logic                 busy
);

    localparam int RW = cnt_w(NUM_LINES);

    state_t               r_state;
    logic [RW-1:0]        r_revealed;
    logic                 r_blink_on;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_best;
    logic                 r_new_best;
    logic                 r_restart;
    logic [NUM_LINES-1:0] r_line_en;

    state_t               w_state_nx;
    logic [RW-1:0]        w_revealed_nx;
    logic                 w_blink_nx;
    logic                 w_restart_nx;
    logic [NUM_LINES-1:0] w_line_nx;
    logic                 w_reveal_done;
    logic                 w_blink_done;
    logic                 w_arm_done;
    logic                 w_blinking;

    assign w_blinking = (r_state == S_HOLD) || (r_state == S_ARMED);

    end_screen_seq_tick_divider #(.N(REVEAL_TICKS)) u_reveal_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!module_en || (r_state != S_REVEAL)),
        .i_en   (tick && module_en && (r_state == S_REVEAL)),
        .o_done (w_reveal_done)
    );

    // A restart key in ARMED overrides the blink so DONE always starts steady.
    end_screen_seq_tick_divider #(.N(BLINK_TICKS)) u_blink_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!module_en || !w_blinking),
        .i_en   (tick && module_en && w_blinking && !((r_state == S_ARMED) && key_restart)),
        .o_done (w_blink_done)
    );

    end_screen_seq_tick_divider #(.N(ARM_TICKS)) u_arm_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!module_en || (r_state != S_HOLD)),
        .i_en   (tick && module_en && (r_state == S_HOLD)),
        .o_done (w_arm_done)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_revealed_nx = r_revealed;
        w_blink_nx    = r_blink_on;
        w_restart_nx  = 1'b0;
        w_line_nx     = '0;
        if (!module_en) begin
            w_state_nx    = S_IDLE;
            w_revealed_nx = '0;
            w_blink_nx    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx    = (NUM_LINES == 1) ? S_HOLD : S_REVEAL;
                    w_revealed_nx = RW'(1);
                    w_blink_nx    = 1'b1;
                end
                S_REVEAL: begin
                    if (w_reveal_done) begin
                        w_revealed_nx = r_revealed + 1'b1;
                        if (r_revealed == RW'(NUM_LINES - 1)) begin
                            w_state_nx = S_HOLD;
                            w_blink_nx = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_blink_done) w_blink_nx = !r_blink_on;
                    if (w_arm_done)   w_state_nx = S_ARMED;
                end
                S_ARMED: begin
                    if (key_restart) begin
                        w_state_nx   = S_DONE;
                        w_restart_nx = 1'b1;
                        w_blink_nx   = 1'b1;
                    end else if (w_blink_done) begin
                        w_blink_nx = !r_blink_on;
                    end
                end
                S_DONE:  w_blink_nx = 1'b1;
                default: w_state_nx = S_IDLE;
            endcase
        end
        // Enables are computed from next-cycle values so they line up with the state register.
        for (int i = 0; i < NUM_LINES; i++) begin
            w_line_nx[i] = (w_state_nx != S_IDLE) && (RW'(i) < w_revealed_nx) &&
                           (!BLINK_MASK[i] || w_blink_nx || (w_state_nx == S_REVEAL));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_revealed <= '0;
            r_blink_on <= 1'b1;
            r_restart  <= 1'b0;
            r_line_en  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_revealed <= w_revealed_nx;
            r_blink_on <= w_blink_nx;
            r_restart  <= w_restart_nx;
            r_line_en  <= w_line_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_score    <= '0;
            r_best     <= '0;
            r_new_best <= 1'b0;
        end else begin
            if (!module_en) r_score <= score_in;
            if (module_en && (r_state == S_IDLE)) begin
                if (r_score > r_best) begin
                    r_best     <= r_score;
                    r_new_best <= 1'b1;
                end else begin
                    r_new_best <= 1'b0;
                end
            end
        end
    end

    assign line_en     = r_line_en;
    assign score_out   = r_score;
    assign best_out    = r_best;
    assign new_best    = r_new_best;
    assign restart_req = r_restart;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_end_screen_seq.sv
// tb/tb_end_screen_seq.sv - directed self-checking bench for end_screen_seq at default parameters
module tb_end_screen_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        module_en;
    logic        tick;
    logic [11:0] score_in;
    logic        key_restart;
    logic [2:0]  line_en;
    logic [11:0] score_out;
    logic [11:0] best_out;
    logic        new_best;
    logic        restart_req;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;

    end_screen_seq dut (
        .clk         (clk),
        .rst         (rst),
        .module_en   (module_en),
        .tick        (tick),
        .score_in    (score_in),
        .key_restart (key_restart),
        .line_en     (line_en),
        .score_out   (score_out),
        .best_out    (best_out),
        .new_best    (new_best),
        .restart_req (restart_req),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (restart_req) n_pulse++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cycle();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (9) step();
    endtask

    task automatic round(input logic [11:0] s, input logic [11:0] exp_best, input logic exp_nb);
        module_en = 1'b0;
        score_in  = s;
        step();
        step();
        module_en = 1'b1;
        step();
        chk("round_score", 32'(score_out), 32'(s));
        chk("round_best", 32'(best_out), 32'(exp_best));
        chk("round_new_best", 32'(new_best), 32'(exp_nb));
        module_en = 1'b0;
        step();
        chk("round_nb_hold", 32'(new_best), 32'(exp_nb));
    endtask

    initial begin
        rst = 1'b1; module_en = 1'b0; tick = 1'b0; score_in = '0; key_restart = 1'b0;
        step();
        step();
        chk("rst_line_en", 32'(line_en), 32'h0);
        chk("rst_score", 32'(score_out), 32'h0);
        chk("rst_best", 32'(best_out), 32'h0);
        chk("rst_flags", {29'h0, new_best, restart_req, busy}, 32'h0);
        rst = 1'b0;

        // Reveal
        score_in = 12'd37;
        step();
        chk("score_follow", 32'(score_out), 32'd37);
        module_en = 1'b1;
        step();
        chk("entry_line_en", 32'(line_en), 32'b001);
        chk("entry_busy", 32'(busy), 32'h1);
        chk("entry_new_best", 32'(new_best), 32'h1);
        score_in = 12'd99;
        step();
        chk("score_hold", 32'(score_out), 32'd37);
        tick_cycle();
        chk("reveal_2", 32'(line_en), 32'b011);
        tick_cycle();
        chk("reveal_3", 32'(line_en), 32'b111);

        // Blink in HOLD with key ignored, then ARMED
        key_restart = 1'b1;
        tick_cycle();
        chk("hold_blink_off", 32'(line_en), 32'b011);
        chk("hold_key_ignored", 32'(n_pulse), 32'd0);
        key_restart = 1'b0;
        tick_cycle();
        chk("armed_blink_on", 32'(line_en), 32'b111);
        tick_cycle();
        chk("armed_blink_off", 32'(line_en), 32'b011);

        // Restart
        key_restart = 1'b1;
        step();
        chk("restart_pulse", 32'(restart_req), 32'h1);
        chk("done_line_en", 32'(line_en), 32'b111);
        step();
        chk("restart_one_cycle", 32'(restart_req), 32'h0);
        repeat (5) step();
        tick_cycle();
        chk("restart_no_repeat", 32'(n_pulse), 32'd1);
        chk("done_busy", 32'(busy), 32'h1);
        chk("done_steady", 32'(line_en), 32'b111);
        key_restart = 1'b0;
        module_en = 1'b0;
        step();
        chk("exit_busy", 32'(busy), 32'h0);
        chk("exit_line_en", 32'(line_en), 32'h0);

        // Best score tracking
        round(12'd50, 12'd50, 1'b1);
        round(12'd20, 12'd50, 1'b0);
        round(12'd80, 12'd80, 1'b1);

        // Abort during reveal and re-entry
        score_in = 12'd5;
        step();
        module_en = 1'b1;
        step();
        tick_cycle();
        chk("abort_pre", 32'(line_en), 32'b011);
        module_en = 1'b0;
        step();
        chk("abort_line_en", 32'(line_en), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        module_en = 1'b1;
        step();
        chk("reentry_line_en", 32'(line_en), 32'b001);
        chk("reentry_best", 32'(best_out), 32'd80);
        chk("reentry_new_best", 32'(new_best), 32'h0);

        // Tick, key and module_en falling together in ARMED
        tick_cycle();
        tick_cycle();
        tick_cycle();
        tick_cycle();
        chk("corner_armed", 32'(line_en), 32'b111);
        tick = 1'b1; key_restart = 1'b1; module_en = 1'b0;
        step();
        tick = 1'b0; key_restart = 1'b0;
        chk("corner_no_pulse", 32'(restart_req), 32'h0);
        chk("corner_idle", 32'(busy), 32'h0);
        chk("corner_line_en", 32'(line_en), 32'h0);
        step();
        chk("corner_pulse_cnt", 32'(n_pulse), 32'd1);

        // Reset mid-HOLD
        module_en = 1'b1;
        step();
        tick_cycle();
        tick_cycle();
        tick_cycle();
        chk("pre_rst_hold", 32'(line_en), 32'b011);
        rst = 1'b1;
        step();
        chk("midrst_line_en", 32'(line_en), 32'h0);
        chk("midrst_best", 32'(best_out), 32'h0);
        chk("midrst_score", 32'(score_out), 32'h0);
        chk("midrst_flags", {29'h0, new_best, restart_req, busy}, 32'h0);
        rst = 1'b0;
        module_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
